// File: rtl/jtag_scan_sequencer_pkg.sv
// Shared definitions for the mote JTAG scan sequencer: widths, command and
// state encodings, entry/exit TMS patterns (all LSB = first slot), and small
// helpers that derive slot counts and patterns from a command.
package jtag_scan_sequencer_pkg;

  localparam int unsigned MAX_LEN = 32;
  localparam int unsigned LEN_W   = 5;
  localparam int unsigned SLOT_W  = 6;
  localparam int unsigned DIV_W   = 8;

  typedef enum logic [1:0] {
    CMD_DR   = 2'd0,
    CMD_IR   = 2'd1,
    CMD_RST  = 2'd2,
    CMD_IDLE = 2'd3
  } cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRE   = 3'd1,
    ST_SHIFT = 3'd2,
    ST_POST  = 3'd3,
    ST_FIN   = 3'd4
  } state_e;

  localparam logic [2:0]  DR_PRE      = 3'b001;
  localparam int unsigned DR_PRE_LEN  = 3;
  localparam logic [3:0]  IR_PRE      = 4'b0011;
  localparam int unsigned IR_PRE_LEN  = 4;
  localparam logic [1:0]  POST_PAT    = 2'b01;
  localparam int unsigned POST_LEN    = 2;
  localparam logic [5:0]  RST_PAT     = 6'b011111;
  localparam int unsigned RST_LEN     = 6;

  // len field 0 encodes a full 32-bit scan
  function automatic logic [SLOT_W-1:0] eff_len(input logic [LEN_W-1:0] len);
    return (len == '0) ? SLOT_W'(MAX_LEN) : SLOT_W'(len);
  endfunction

  function automatic logic is_scan(input cmd_e c);
    return (c == CMD_DR) || (c == CMD_IR);
  endfunction

  // Number of PRE slots; idle clocking is all PRE
  function automatic logic [SLOT_W-1:0] pre_len(input cmd_e c, input logic [SLOT_W-1:0] l);
    logic [SLOT_W-1:0] n;
    case (c)
      CMD_DR:  n = SLOT_W'(DR_PRE_LEN);
      CMD_IR:  n = SLOT_W'(IR_PRE_LEN);
      CMD_RST: n = SLOT_W'(RST_LEN);
      default: n = l;
    endcase
    return n;
  endfunction

  // PRE TMS pattern; idle clocking holds TMS low
  function automatic logic [7:0] pre_pat(input cmd_e c);
    logic [7:0] p;
    case (c)
      CMD_DR:  p = 8'(DR_PRE);
      CMD_IR:  p = 8'(IR_PRE);
      CMD_RST: p = 8'(RST_PAT);
      default: p = '0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/jtag_scan_sequencer_if.sv
// Command/result handshake plus mote JTAG pins for the scan sequencer.
//   master: issues start/cmd/len/tdi_data, returns tdo; sees busy/done/tdo_data/tck/tms/tdi
//   slave : the sequencer side
interface jtag_scan_sequencer_if;
  import jtag_scan_sequencer_pkg::*;

  logic               start;
  logic [1:0]         cmd;
  logic [LEN_W-1:0]   len;
  logic [MAX_LEN-1:0] tdi_data;
  logic               busy;
  logic               done;
  logic [MAX_LEN-1:0] tdo_data;
  logic               tck;
  logic               tms;
  logic               tdi;
  logic               tdo;

  modport master (
    output start, cmd, len, tdi_data, tdo,
    input  busy, done, tdo_data, tck, tms, tdi
  );

  modport slave (
    input  start, cmd, len, tdi_data, tdo,
    output busy, done, tdo_data, tck, tms, tdi
  );

endinterface

// File: rtl/jtag_scan_sequencer_tck_gen.sv
// Divided TCK generator. While en_i is high, TCK alternates low/high phases of
// HALF_DIV clk cycles each, starting with a low phase; en_i low clears it.
//   clk, reset   : main clock, async active-high reset
//   en_i         : run enable
//   tck_o        : registered TCK
//   rise_stb_o   : high in the first clk cycle of each high phase (tdo sample cycle)
//   fall_stb_o   : high in the last clk cycle of each high phase, so registered
//                  tms/tdi updated on that edge change together with TCK falling
module jtag_tck_gen
  import jtag_scan_sequencer_pkg::*;
#(
  parameter int unsigned HALF_DIV = 6
) (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  output logic tck_o,
  output logic rise_stb_o,
  output logic fall_stb_o
);

  localparam logic [DIV_W-1:0] LAST     = DIV_W'(HALF_DIV - 1);
  localparam logic [DIV_W-1:0] PRE_LAST = DIV_W'(HALF_DIV - 2);

  logic [DIV_W-1:0] cnt_q;
  logic             tck_q;
  logic             rise_q;
  logic             fall_q;
  logic             wrap;

  assign wrap = (cnt_q == LAST);

  // Phase counter and strobe registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      tck_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else if (!en_i) begin
      cnt_q  <= '0;
      tck_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      cnt_q  <= wrap ? '0 : cnt_q + DIV_W'(1);
      if (wrap) tck_q <= ~tck_q;
      rise_q <= wrap && !tck_q;
      fall_q <= tck_q && (cnt_q == PRE_LAST);
    end
  end

  assign tck_o      = tck_q;
  assign rise_stb_o = rise_q;
  assign fall_stb_o = fall_q;

endmodule

// File: rtl/jtag_scan_sequencer.sv
// Runs one complete JTAG scan command on the mote TAP, from Run-Test/Idle back
// to Run-Test/Idle: DR scan, IR scan, TAP reset or idle clocking.
//   clk, reset : main clock, async active-high reset
//   bus.start/cmd/len/tdi_data : command strobe and operands (taken when busy=0)
//   bus.busy/done/tdo_data     : status, one-cycle completion, captured TDO
//   bus.tck/tms/tdi, bus.tdo   : mote JTAG pins
module jtag_scan_sequencer
  import jtag_scan_sequencer_pkg::*;
#(
  parameter int unsigned HALF_DIV = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  jtag_scan_sequencer_if.slave bus
);

  state_e              state_q, state_d;
  cmd_e                cmd_q;
  logic [SLOT_W-1:0]   len_q;
  logic [SLOT_W-1:0]   idx_q, idx_d;
  logic [MAX_LEN-1:0]  data_q;
  logic [MAX_LEN-1:0]  tdo_q;
  logic                tms_q, tdi_q;
  logic                busy_q, done_q;
  logic [1:0]          drive_d;
  logic                tck, rise_stb, fall_stb;
  cmd_e                cmd_in;
  logic [7:0]          start_pat;

  jtag_tck_gen #(.HALF_DIV(HALF_DIV)) u_tck_gen (
    .clk        (clk),
    .reset      (reset),
    .en_i       (busy_q),
    .tck_o      (tck),
    .rise_stb_o (rise_stb),
    .fall_stb_o (fall_stb)
  );

  // {tms, tdi} for a slot; FIN/IDLE keep tms low, matching every last slot
  function automatic logic [1:0] slot_drive(input state_e st, input logic [SLOT_W-1:0] idx,
                                            input cmd_e c, input logic [SLOT_W-1:0] l,
                                            input logic [MAX_LEN-1:0] d);
    logic       tms, tdi;
    logic [7:0] pat;
    tms = 1'b0;
    tdi = 1'b0;
    pat = pre_pat(c);
    case (st)
      ST_PRE:   tms = pat[idx[2:0]];
      ST_SHIFT: begin
        tms = (idx == l - SLOT_W'(1));
        tdi = d[idx[4:0]];
      end
      ST_POST:  tms = POST_PAT[idx[0]];
      default:  ;
    endcase
    return {tms, tdi};
  endfunction

  // Slot advance: where the next slot lives and what it drives
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q + SLOT_W'(1);
    case (state_q)
      ST_PRE: if (idx_q == pre_len(cmd_q, len_q) - SLOT_W'(1)) begin
        idx_d   = '0;
        state_d = is_scan(cmd_q) ? ST_SHIFT : ST_FIN;
      end
      ST_SHIFT: if (idx_q == len_q - SLOT_W'(1)) begin
        idx_d   = '0;
        state_d = ST_POST;
      end
      ST_POST: if (idx_q == SLOT_W'(POST_LEN - 1)) begin
        idx_d   = '0;
        state_d = ST_FIN;
      end
      default: idx_d = idx_q;
    endcase
    drive_d = slot_drive(state_d, idx_d, cmd_q, len_q, data_q);
  end

  assign cmd_in    = cmd_e'(bus.cmd);
  assign start_pat = pre_pat(cmd_in);

  // Sequencer FSM; a start in FIN is accepted so commands chain back-to-back
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cmd_q   <= CMD_DR;
      len_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      tdo_q   <= '0;
      tms_q   <= 1'b1;
      tdi_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_FIN: begin
          if (bus.start) begin
            state_q <= ST_PRE;
            cmd_q   <= cmd_in;
            len_q   <= eff_len(bus.len);
            data_q  <= bus.tdi_data;
            tdo_q   <= '0;
            idx_q   <= '0;
            tms_q   <= start_pat[0];
            tdi_q   <= 1'b0;
            busy_q  <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          if (rise_stb && state_q == ST_SHIFT) tdo_q[idx_q[4:0]] <= bus.tdo;
          if (fall_stb) begin
            state_q <= state_d;
            idx_q   <= idx_d;
            {tms_q, tdi_q} <= drive_d;
            if (state_d == ST_FIN) begin
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign bus.tck      = tck;
  assign bus.tms      = tms_q;
  assign bus.tdi      = tdi_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.tdo_data = tdo_q;

endmodule
